spi_readback_rx: RTL and testbench
==================================

Name: spi_readback_rx

Overview:
- FPGA-side receiver for the serial readback path of the SPI_2909 shift-register chain.
- Generates the serial shift clock and REGSEL toward the chip, and samples the chip's SOUT line MSB-first.
- Assembles WORD_W bits into a parallel word and hands it to the consumer with a valid/ready handshake.
- Complements the existing write path, which drives SIN, REGSEL, clk and GRST; the two paths time-share clk/REGSEL through an external mux, and busy is the arbitration signal.

Parameters:
- WORD_W, 32, number of bits captured per readback transaction (1..64).
- CLK_DIV, 2, SCLK cycles per half-period of the generated shift clock (>=1).
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WORD_W.

Ports:
- SCLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a readback; honoured only in IDLE.
- regsel_in  in  1  register select latched at start and driven on REGSEL for the whole transaction.
- abort  in  1  cancels an in-flight transaction.
- SOUT  in  1  serial data from the chip, already synchronised to SCLK.
- rx_ready  in  1  consumer accepts rx_data.
- clk  out  1  generated shift clock to the chip.
- REGSEL  out  1  register select to the chip.
- busy  out  1  high in any state other than IDLE.
- rx_data  out  WORD_W  captured word; MSB is the first bit sampled.
- rx_valid  out  1  rx_data is valid.
- start_err  out  1  sticky flag; set by start arriving while not IDLE.

Behaviour:
- Reset (async, RST=1) values:
  - State: IDLE.
  - clk=0, REGSEL=0, busy=0, rx_valid=0, start_err=0.
  - rx_data=0, bit counter=0, phase counter=0.
- States: IDLE, SETUP, LOW, HIGH, DONE.
- IDLE:
  - clk=0.
  - On start=1: latch regsel_in into REGSEL, clear the shift register, go to SETUP.
- SETUP:
  - clk=0, lasts exactly CLK_DIV cycles, giving REGSEL setup time to the chip.
  - Then go to LOW.
- LOW:
  - clk=0, lasts CLK_DIV cycles.
  - On its last cycle: sample SOUT into the shift register LSB (shift left), then go to HIGH. clk is registered high in the same edge.
- HIGH:
  - clk=1, lasts CLK_DIV cycles.
  - Then increment the bit counter.
  - If the count reaches WORD_W, go to DONE; otherwise go to LOW.
- Edge and sample count:
  - Exactly WORD_W rising edges of clk per transaction.
  - Exactly WORD_W samples, each taken one SCLK before its rising edge.
  - The first sample reads the bit already present on SOUT.
- DONE:
  - clk=0, rx_valid=1, rx_data holds the word, REGSEL holds its value.
  - On rx_ready=1: rx_valid drops on the next edge and the state returns to IDLE. REGSEL returns to 0.
  - rx_ready while rx_valid=0 has no effect.
- Latency:
  - With start seen at cycle 0, rx_valid rises at cycle 1 + CLK_DIV + 2*CLK_DIV*WORD_W.
  - Defaults: cycle 131.
- rx_data is stable throughout DONE and retains its value in IDLE until the next SETUP clears the shift register.
- start_err:
  - Set when start=1 in any state other than IDLE; that start is otherwise ignored.
  - Cleared only by RST.
- abort=1 in SETUP, LOW or HIGH:
  - Next cycle: state IDLE, clk=0, REGSEL=0, no rx_valid pulse.
  - The partial word is discarded; rx_data keeps its old value.
  - abort in DONE or IDLE is ignored.
- Simultaneous events:
  - abort has priority over the HIGH->DONE transition.
  - start and rx_ready in the same DONE cycle: rx_ready is honoured, start is ignored and sets start_err.
- RST asserted mid-transaction: all outputs return to reset values immediately. clk is forced low asynchronously, which may truncate a high phase.
- No combinational paths from inputs to outputs; all outputs are registered.

Decomposition:
- Package spi_rb_pkg:
  - State encoding constants (IDLE, SETUP, LOW, HIGH, DONE).
  - Default values of WORD_W and CLK_DIV.
  - A function computing CNT_W from WORD_W.
- Sub-module spi_clk_phase:
  - Counts CLK_DIV cycles.
  - Outputs a phase_last pulse on the final cycle of each half-period.
  - Has restart and enable inputs.
  - The FSM, shift register and handshake stay in spi_readback_rx.

Test Plan:
- Basic capture: defaults, SOUT model presents 32'hA5C3_0F96 MSB-first, changing after each clk rise.
  - Required: rx_valid at cycle 131, rx_data=32'hA5C3_0F96.
  - Required: exactly 32 clk rising edges, REGSEL=regsel_in throughout.
- Backpressure: hold rx_ready=0 for 20 cycles after rx_valid.
  - Required: rx_valid and rx_data stay constant, clk stays 0, busy=1.
  - Required: rx_ready=1 gives rx_valid=0 and busy=0 on the next cycle.
- Abort: pulse abort after the 10th clk rise.
  - Required: clk=0, REGSEL=0, busy=0 next cycle, no rx_valid, rx_data unchanged from the prior word.
- Start while busy: pulse start during HIGH of bit 5.
  - Required: start_err=1 and remains set, the transaction completes normally with the correct word.
  - Required: start_err is cleared only by RST.
- Reset mid-transfer: assert RST during a HIGH phase.
  - Required: clk=0 and all outputs at reset values within the same cycle.
  - Required: after release, a new start captures 32'hFFFF_0000 correctly.
- Parameter sweep: WORD_W=8, CLK_DIV=1, pattern 8'h81.
  - Required: rx_valid at cycle 1+1+16=18, rx_data=8'h81, clk period of 2 SCLK cycles.

Source files
------------

// File: rtl/spi_rb_pkg.sv
// Shared types and defaults for the SPI_2909 readback receiver.
package spi_rb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    DONE
  } rb_state_t;

  localparam int WORD_W_DEF  = 32;
  localparam int CLK_DIV_DEF = 2;

  // Smallest bit-counter width that can hold the value WORD_W itself.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/spi_readback_rx_if.sv
// Chip-facing and consumer-facing signals of the readback receiver.
interface spi_readback_rx_if #(
  parameter int WORD_W = 32
);

  logic              start;
  logic              regsel_in;
  logic              abort;
  logic              SOUT;
  logic              rx_ready;
  logic              clk;
  logic              REGSEL;
  logic              busy;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              start_err;

  modport master (
    output start, regsel_in, abort, SOUT, rx_ready,
    input  clk, REGSEL, busy, rx_data, rx_valid, start_err
  );

  modport slave (
    input  start, regsel_in, abort, SOUT, rx_ready,
    output clk, REGSEL, busy, rx_data, rx_valid, start_err
  );

endinterface

// File: rtl/spi_clk_phase.sv
// Half-period timer for the generated shift clock; phase_last marks the
// final SCLK cycle of each CLK_DIV-long phase.
module spi_clk_phase
  import spi_rb_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic SCLK,
  input  logic RST,
  input  logic restart,
  input  logic enable,
  output logic phase_last
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase_cnt;

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      phase_cnt <= '0;
    end else if (restart) begin
      phase_cnt <= '0;
    end else if (enable) begin
      phase_cnt <= (phase_cnt == LAST) ? '0 : phase_cnt + PW'(1);
    end
  end

  assign phase_last = enable && (phase_cnt == LAST);

endmodule

// File: rtl/spi_readback_rx.sv
// Readback receiver for the SPI_2909 chain: drives clk/REGSEL, samples SOUT
// MSB-first and presents the assembled word on a valid/ready handshake.
module spi_readback_rx
  import spi_rb_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CNT_W   = cnt_width(WORD_W)
) (
  input logic              SCLK,
  input logic              RST,
  spi_readback_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  rb_state_t         state, state_nxt;
  logic [WORD_W-1:0] shift_reg, shift_nxt;
  logic [WORD_W-1:0] data_q, data_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              regsel_q, regsel_nxt;
  logic              err_q, err_nxt;
  logic              clk_q, busy_q, valid_q;
  logic              phase_last, phase_en, phase_restart;

  assign phase_en      = state inside {SETUP, LOW, HIGH};
  assign phase_restart = (state == IDLE);

  spi_clk_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .SCLK       (SCLK),
    .RST        (RST),
    .restart    (phase_restart),
    .enable     (phase_en),
    .phase_last (phase_last)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    data_nxt    = data_q;
    bit_cnt_nxt = bit_cnt;
    regsel_nxt  = regsel_q;
    err_nxt     = err_q | (bus.start && (state != IDLE));

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt   = SETUP;
          regsel_nxt  = bus.regsel_in;
          shift_nxt   = '0;
          bit_cnt_nxt = '0;
        end
      end
      SETUP: begin
        if (bus.abort) begin
          state_nxt  = IDLE;
          regsel_nxt = 1'b0;
        end else if (phase_last) begin
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (bus.abort) begin
          state_nxt  = IDLE;
          regsel_nxt = 1'b0;
        end else if (phase_last) begin
          // Sample on the same edge that raises clk, so the chip has not yet
          // shifted out its next bit.
          shift_nxt = (shift_reg << 1) | WORD_W'(bus.SOUT);
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (bus.abort) begin
          state_nxt  = IDLE;
          regsel_nxt = 1'b0;
        end else if (phase_last) begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt = DONE;
            data_nxt  = shift_reg;
          end else begin
            state_nxt = LOW;
          end
        end
      end
      DONE: begin
        if (bus.rx_ready) begin
          state_nxt  = IDLE;
          regsel_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        regsel_nxt = 1'b0;
      end
    endcase
  end

  // Every output is registered from the next state, keeping inputs off any
  // combinational path to the pins.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      data_q    <= '0;
      bit_cnt   <= '0;
      regsel_q  <= 1'b0;
      err_q     <= 1'b0;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      data_q    <= data_nxt;
      bit_cnt   <= bit_cnt_nxt;
      regsel_q  <= regsel_nxt;
      err_q     <= err_nxt;
      clk_q     <= (state_nxt == HIGH);
      busy_q    <= (state_nxt != IDLE);
      valid_q   <= (state_nxt == DONE);
    end
  end

  assign bus.clk       = clk_q;
  assign bus.REGSEL    = regsel_q;
  assign bus.busy      = busy_q;
  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.start_err = err_q;

endmodule

// File: tb/tb_spi_readback_rx.sv
// Directed bench for spi_readback_rx: a 32-bit/CLK_DIV=2 instance and an
// 8-bit/CLK_DIV=1 instance, each fed by a simple chip model on SOUT.
module tb_spi_readback_rx;

  logic SCLK = 1'b0;
  logic RST;
  int   vectors = 0;
  int   miscompares = 0;

  spi_readback_rx_if #(.WORD_W(32)) bus0();
  spi_readback_rx_if #(.WORD_W(8))  bus1();

  spi_readback_rx #(.WORD_W(32), .CLK_DIV(2)) dut0 (
    .SCLK (SCLK),
    .RST  (RST),
    .bus  (bus0)
  );

  spi_readback_rx #(.WORD_W(8), .CLK_DIV(1)) dut1 (
    .SCLK (SCLK),
    .RST  (RST),
    .bus  (bus1)
  );

  always #5 SCLK = ~SCLK;

  // Chip model: presents the current pattern MSB-first, advancing one bit
  // after every rising edge of the generated clk.
  logic [31:0] pat0 = '0;
  logic [7:0]  pat1 = '0;
  int rises0 = 0, base0 = 0, rel0;
  int rises1 = 0, base1 = 0, rel1;

  always @(posedge bus0.clk) rises0 = rises0 + 1;
  always @(posedge bus1.clk) rises1 = rises1 + 1;

  assign rel0 = rises0 - base0;
  assign rel1 = rises1 - base1;
  assign bus0.SOUT = (rel0 >= 0 && rel0 < 32) ? pat0[31 - rel0] : 1'b0;
  assign bus1.SOUT = (rel1 >= 0 && rel1 < 8)  ? pat1[7 - rel1]  : 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pattern, input logic regsel);
    pat0 = pattern;
    base0 = rises0;
    bus0.regsel_in = regsel;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
  endtask

  // cyc counts SCLK edges from the cycle in which start was driven.
  task automatic waitValid0(output int cyc);
    cyc = 1;
    while (bus0.rx_valid !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic waitRises0(input int n, input string tag);
    int guard = 0;
    while (rel0 < n && guard < 1000) begin
      tick();
      guard++;
    end
    checkOutput(tag, 64'(rel0 >= n), 64'd1);
  endtask

  task automatic handshake0();
    bus0.rx_ready = 1'b1;
    tick();
    bus0.rx_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int r0;
    logic bad_a, bad_b, bad_c, bad_d;

    RST = 1'b1;
    {bus0.start, bus0.regsel_in, bus0.abort, bus0.rx_ready} = '0;
    {bus1.start, bus1.regsel_in, bus1.abort, bus1.rx_ready} = '0;
    tick();
    tick();

    checkOutput("rst_clk",    bus0.clk, 0);
    checkOutput("rst_regsel", bus0.REGSEL, 0);
    checkOutput("rst_busy",   bus0.busy, 0);
    checkOutput("rst_valid",  bus0.rx_valid, 0);
    checkOutput("rst_err",    bus0.start_err, 0);
    checkOutput("rst_data",   bus0.rx_data, 0);
    checkOutput("rst_data8",  bus1.rx_data, 0);

    RST = 1'b0;
    tick();

    // Basic capture with REGSEL=1 held across the whole transaction.
    $display("[TB] basic capture");
    r0 = rises0;
    applyStimulus(32'hA5C3_0F96, 1'b1);
    bad_a = 1'b0;
    cyc = 1;
    while (bus0.rx_valid !== 1'b1 && cyc < 1000) begin
      if (bus0.REGSEL !== 1'b1) bad_a = 1'b1;
      tick();
      cyc++;
    end
    checkOutput("basic_latency", 64'(cyc), 64'd131);
    checkOutput("basic_data",    bus0.rx_data, 64'hA5C3_0F96);
    checkOutput("basic_rises",   64'(rises0 - r0), 64'd32);
    checkOutput("basic_regsel",  bad_a, 0);
    checkOutput("done_regsel",   bus0.REGSEL, 1);
    checkOutput("done_clk",      bus0.clk, 0);

    // Backpressure: consumer stalls for 20 cycles.
    $display("[TB] backpressure");
    {bad_a, bad_b, bad_c, bad_d} = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus0.rx_valid !== 1'b1) bad_a = 1'b1;
      if (bus0.rx_data !== 32'hA5C3_0F96) bad_b = 1'b1;
      if (bus0.clk !== 1'b0) bad_c = 1'b1;
      if (bus0.busy !== 1'b1) bad_d = 1'b1;
    end
    checkOutput("bp_valid_hold", bad_a, 0);
    checkOutput("bp_data_hold",  bad_b, 0);
    checkOutput("bp_clk_low",    bad_c, 0);
    checkOutput("bp_busy",       bad_d, 0);
    handshake0();
    checkOutput("ack_valid",  bus0.rx_valid, 0);
    checkOutput("ack_busy",   bus0.busy, 0);
    checkOutput("ack_regsel", bus0.REGSEL, 0);
    tick();
    checkOutput("idle_data",  bus0.rx_data, 64'hA5C3_0F96);

    // Abort right after the 10th clk rise.
    $display("[TB] abort");
    applyStimulus(32'h1234_5678, 1'b1);
    waitRises0(10, "abort_wait");
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    checkOutput("abort_clk",    bus0.clk, 0);
    checkOutput("abort_regsel", bus0.REGSEL, 0);
    checkOutput("abort_busy",   bus0.busy, 0);
    checkOutput("abort_data",   bus0.rx_data, 64'hA5C3_0F96);
    bad_a = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (bus0.rx_valid !== 1'b0) bad_a = 1'b1;
      tick();
    end
    checkOutput("abort_no_valid", bad_a, 0);

    // Stray start during HIGH of bit 5, then start+ready together in DONE.
    $display("[TB] start while busy");
    applyStimulus(32'h3C5A_96E1, 1'b0);
    waitRises0(6, "sb_wait");
    checkOutput("sb_in_high", bus0.clk, 1);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    checkOutput("sb_err_set", bus0.start_err, 1);
    waitValid0(cyc);
    checkOutput("sb_valid",  bus0.rx_valid, 1);
    checkOutput("sb_data",   bus0.rx_data, 64'h3C5A_96E1);
    checkOutput("sb_err_held", bus0.start_err, 1);
    bus0.start = 1'b1;
    bus0.rx_ready = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.rx_ready = 1'b0;
    checkOutput("sr_valid", bus0.rx_valid, 0);
    checkOutput("sr_busy",  bus0.busy, 0);
    tick();
    tick();
    checkOutput("sr_start_ignored", bus0.busy, 0);
    checkOutput("sr_err_sticky",    bus0.start_err, 1);

    // Reset in the middle of a HIGH phase.
    $display("[TB] reset mid-transfer");
    applyStimulus(32'hDEAD_BEEF, 1'b1);
    waitRises0(3, "rst_wait");
    #2;
    RST = 1'b1;
    #1;
    checkOutput("mr_clk",    bus0.clk, 0);
    checkOutput("mr_regsel", bus0.REGSEL, 0);
    checkOutput("mr_busy",   bus0.busy, 0);
    checkOutput("mr_valid",  bus0.rx_valid, 0);
    checkOutput("mr_err",    bus0.start_err, 0);
    checkOutput("mr_data",   bus0.rx_data, 0);
    tick();
    RST = 1'b0;
    tick();
    applyStimulus(32'hFFFF_0000, 1'b1);
    waitValid0(cyc);
    checkOutput("mr_latency", 64'(cyc), 64'd131);
    checkOutput("mr_new_data", bus0.rx_data, 64'hFFFF_0000);
    handshake0();

    // Narrow instance: WORD_W=8, CLK_DIV=1.
    $display("[TB] parameter sweep");
    pat1 = 8'h81;
    base1 = rises1;
    bus1.regsel_in = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bad_a = 1'b0;
    cyc = 1;
    while (bus1.rx_valid !== 1'b1 && cyc < 1000) begin
      if (cyc >= 3 && bus1.clk !== cyc[0]) bad_a = 1'b1;
      tick();
      cyc++;
    end
    checkOutput("w8_latency", 64'(cyc), 64'd18);
    checkOutput("w8_data",    bus1.rx_data, 64'h81);
    checkOutput("w8_rises",   64'(rel1), 64'd8);
    checkOutput("w8_period",  bad_a, 0);
    bus1.rx_ready = 1'b1;
    tick();
    bus1.rx_ready = 1'b0;
    checkOutput("w8_ack_busy", bus1.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
